// File: rtl/serial_subtractor_ctrl_pkg.sv
// Shared definitions for the bit-serial subtractor: FSM encodings, the
// half-subtractor primitive and the counter sizing helper.
package serial_subtractor_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } sub_state_e;

    typedef struct packed {
        logic diff;
        logic bout;
    } hsub_t;

    function automatic hsub_t half_sub(input logic x, input logic y);
        hsub_t r;
        r.diff = x ^ y;
        r.bout = ~x & y;
        return r;
    endfunction

    // Counter must reach WIDTH-1; never narrower than one bit.
    function automatic int cnt_width(input int w);
        return (w < 2) ? 1 : $clog2(w + 1);
    endfunction

endpackage

// File: rtl/full_subtractor_bit.sv
// One-bit full subtractor: two cascaded half subtractors whose borrows are ORed.
module full_subtractor_bit
    import serial_subtractor_ctrl_pkg::*;
(
    input  logic a,
    input  logic b,
    input  logic bin,
    output logic diff,
    output logic bout
);

    hsub_t hs_ab;
    hsub_t hs_bin;

    always_comb begin
        hs_ab  = half_sub(a, b);
        hs_bin = half_sub(hs_ab.diff, bin);
    end

    assign diff = hs_bin.diff;
    assign bout = hs_ab.bout | hs_bin.bout;

endmodule

// File: rtl/serial_subtractor_ctrl.sv
// Bit-serial a-b controller: feeds one full_subtractor_bit LSB first and
// keeps the borrow in a register between cycles; start/busy/done handshake.
module serial_subtractor_ctrl
    import serial_subtractor_ctrl_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             bout
);

    localparam int CNT_W = cnt_width(WIDTH);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    sub_state_e       state_q, state_d;
    logic [WIDTH-1:0] a_sr_q, a_sr_d;
    logic [WIDTH-1:0] b_sr_q, b_sr_d;
    logic [WIDTH-1:0] res_sr_q, res_sr_d;
    logic [WIDTH-1:0] diff_q, diff_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             borrow_q, borrow_d;
    logic             bout_q, bout_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic             bit_diff;
    logic             bit_bout;
    logic [WIDTH-1:0] res_next;

    full_subtractor_bit u_bit (
        .a    (a_sr_q[0]),
        .b    (b_sr_q[0]),
        .bin  (borrow_q),
        .diff (bit_diff),
        .bout (bit_bout)
    );

    // New difference bit enters at the MSB so the LSB lands at bit 0 after WIDTH shifts.
    generate
        if (WIDTH == 1) begin : g_res_w1
            assign res_next = bit_diff;
        end else begin : g_res_wn
            assign res_next = {bit_diff, res_sr_q[WIDTH-1:1]};
        end
    endgenerate

    always_comb begin
        state_d  = state_q;
        a_sr_d   = a_sr_q;
        b_sr_d   = b_sr_q;
        res_sr_d = res_sr_q;
        diff_d   = diff_q;
        cnt_d    = cnt_q;
        borrow_d = borrow_q;
        bout_d   = bout_q;
        busy_d   = 1'b0;
        done_d   = 1'b0;

        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    a_sr_d   = a;
                    b_sr_d   = b;
                    res_sr_d = '0;
                    cnt_d    = '0;
                    borrow_d = 1'b0;
                    busy_d   = 1'b1;
                    state_d  = SHIFT;
                end else begin
                    state_d  = IDLE;
                end
            end
            SHIFT: begin
                a_sr_d   = a_sr_q >> 1;
                b_sr_d   = b_sr_q >> 1;
                res_sr_d = res_next;
                borrow_d = bit_bout;
                cnt_d    = cnt_q + CNT_W'(1);
                busy_d   = 1'b1;
                if (cnt_q == LAST_CNT) begin
                    diff_d  = res_next;
                    bout_d  = bit_bout;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    state_d = DONE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            a_sr_q   <= '0;
            b_sr_q   <= '0;
            res_sr_q <= '0;
            diff_q   <= '0;
            cnt_q    <= '0;
            borrow_q <= 1'b0;
            bout_q   <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_sr_q   <= a_sr_d;
            b_sr_q   <= b_sr_d;
            res_sr_q <= res_sr_d;
            diff_q   <= diff_d;
            cnt_q    <= cnt_d;
            borrow_q <= borrow_d;
            bout_q   <= bout_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign diff = diff_q;
    assign bout = bout_q;

endmodule

// File: tb/tb_serial_subtractor_ctrl.sv
// Bench for serial_subtractor_ctrl: WIDTH=8 and WIDTH=1 instances, a
// cycle-level countdown/arithmetic model and directed literal checks.
module tb_serial_subtractor_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n = 1'b0;
    logic       start0 = 1'b0;
    logic [7:0] a0 = 8'h00, b0 = 8'h00;
    logic       busy0, done0, bout0;
    logic [7:0] diff0;
    logic       start1 = 1'b0;
    logic [0:0] a1 = 1'b0, b1 = 1'b0;
    logic       busy1, done1, bout1;
    logic [0:0] diff1;

    serial_subtractor_ctrl #(.WIDTH(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .start(start0), .a(a0), .b(b0),
        .busy(busy0), .done(done0), .diff(diff0), .bout(bout0)
    );

    serial_subtractor_ctrl #(.WIDTH(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .a(a1), .b(b1),
        .busy(busy1), .done(done1), .diff(diff1), .bout(bout1)
    );

    int n_chk = 0;
    int n_pass = 0;
    logic chk_en = 1'b0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    // Model: an accepted request finishes WIDTH edges later with (a-b) mod 2^W
    // and borrow a<b; results hold until the next completion or reset.
    logic       m_busy[2] = '{1'b0, 1'b0};
    logic       m_done[2] = '{1'b0, 1'b0};
    logic       m_bout[2] = '{1'b0, 1'b0};
    logic [7:0] m_diff[2] = '{8'h00, 8'h00};
    logic [7:0] p_diff[2] = '{8'h00, 8'h00};
    logic       p_bout[2] = '{1'b0, 1'b0};
    int         m_rem[2]  = '{0, 0};

    always @(posedge clk) begin
        logic       s[2];
        logic [7:0] av[2];
        logic [7:0] bv[2];
        s[0] = start0; av[0] = a0;          bv[0] = b0;
        s[1] = start1; av[1] = {7'd0, a1};  bv[1] = {7'd0, b1};
        for (int k = 0; k < 2; k++) begin
            int         w;
            logic [7:0] mask;
            w    = (k == 0) ? 8 : 1;
            mask = (k == 0) ? 8'hFF : 8'h01;
            if (!rst_n) begin
                m_busy[k] = 1'b0; m_done[k] = 1'b0;
                m_diff[k] = 8'h00; m_bout[k] = 1'b0; m_rem[k] = 0;
            end else if (s[k] && !m_busy[k]) begin
                m_busy[k] = 1'b1;
                m_done[k] = 1'b0;
                m_rem[k]  = w;
                p_diff[k] = (av[k] - bv[k]) & mask;
                p_bout[k] = (av[k] < bv[k]);
            end else if (m_busy[k]) begin
                m_rem[k]--;
                if (m_rem[k] == 0) begin
                    m_busy[k] = 1'b0;
                    m_done[k] = 1'b1;
                    m_diff[k] = p_diff[k];
                    m_bout[k] = p_bout[k];
                end
            end else begin
                m_done[k] = 1'b0;
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("busy8", {31'd0, busy0}, {31'd0, m_busy[0]});
            check("done8", {31'd0, done0}, {31'd0, m_done[0]});
            check("diff8", {24'd0, diff0}, {24'd0, m_diff[0]});
            check("bout8", {31'd0, bout0}, {31'd0, m_bout[0]});
            check("busy1", {31'd0, busy1}, {31'd0, m_busy[1]});
            check("done1", {31'd0, done1}, {31'd0, m_done[1]});
            check("diff1", {24'd0, m_diff[1] & 8'h00 | {7'd0, diff1}}, {24'd0, m_diff[1]});
            check("bout1", {31'd0, bout1}, {31'd0, m_bout[1]});
        end
    end

    // Called at a negedge: present operands, wait for done. Latency is counted in
    // negedges from the presenting one, so W edges after accept reads W+1.
    task automatic run8(input logic [7:0] a, input logic [7:0] b,
                        input logic [7:0] ed, input logic eb, input string nm);
        int lat = 0;
        int bc = 0;
        start0 = 1'b1; a0 = a; b0 = b;
        do begin
            @(negedge clk);
            lat++;
            if (lat == 1) begin
                start0 = 1'b0; a0 = 8'($urandom); b0 = 8'($urandom);
            end
            if (busy0) bc++;
        end while (!done0 && lat < 40);
        check({nm, "_lat"}, lat, 9);
        check({nm, "_busycyc"}, bc, 8);
        check({nm, "_diff"}, {24'd0, diff0}, {24'd0, ed});
        check({nm, "_bout"}, {31'd0, bout0}, {31'd0, eb});
    endtask

    task automatic run1(input logic a, input logic b, input logic ed, input logic eb,
                        input string nm);
        int lat = 0;
        start1 = 1'b1; a1 = a; b1 = b;
        do begin
            @(negedge clk);
            lat++;
            if (lat == 1) start1 = 1'b0;
        end while (!done1 && lat < 10);
        check({nm, "_lat"}, lat, 2);
        check({nm, "_diff"}, {31'd0, diff1}, {31'd0, ed});
        check({nm, "_bout"}, {31'd0, bout1}, {31'd0, eb});
    endtask

    initial begin
        int nd;
        int lat;
        logic [7:0] dv;
        logic seen;

        repeat (2) @(negedge clk);
        chk_en = 1'b1;
        check("rst_busy", {31'd0, busy0}, 32'd0);
        check("rst_done", {31'd0, done0}, 32'd0);
        check("rst_diff", {24'd0, diff0}, 32'd0);
        check("rst_bout", {31'd0, bout0}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        run8(8'h5A, 8'h23, 8'h37, 1'b0, "t5a_23");
        @(negedge clk);
        run8(8'h00, 8'h01, 8'hFF, 1'b1, "t00_01");
        @(negedge clk);
        run8(8'hFF, 8'hFF, 8'h00, 1'b0, "tff_ff");
        @(negedge clk);

        // Start and new operands during SHIFT must be ignored.
        nd = 0; dv = 8'h00;
        start0 = 1'b1; a0 = 8'h5A; b0 = 8'h23;
        for (int i = 1; i <= 14; i++) begin
            @(negedge clk);
            if (i == 1) start0 = 1'b0;
            if (i == 3) begin start0 = 1'b1; a0 = 8'hFF; b0 = 8'h00; end
            if (i == 5) start0 = 1'b0;
            if (done0) begin nd++; dv = diff0; end
        end
        check("ign_npulse", nd, 1);
        check("ign_diff", {24'd0, dv}, 32'h37);

        run8(8'h10, 8'h20, 8'hF0, 1'b1, "t10_20");
        @(negedge clk);

        // Reset during the 4th SHIFT cycle aborts with no done pulse.
        seen = 1'b0;
        start0 = 1'b1; a0 = 8'h5A; b0 = 8'h23;
        for (int i = 1; i <= 4; i++) begin
            @(negedge clk);
            if (i == 1) start0 = 1'b0;
            seen = seen | done0;
        end
        rst_n = 1'b0;
        @(negedge clk);
        check("abort_busy", {31'd0, busy0}, 32'd0);
        check("abort_diff", {24'd0, diff0}, 32'd0);
        check("abort_bout", {31'd0, bout0}, 32'd0);
        check("abort_done", {31'd0, done0 | seen}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        run8(8'h09, 8'h03, 8'h06, 1'b0, "t09_03");
        @(negedge clk);

        // Start held high through DONE: back-to-back completions 9 cycles apart.
        start0 = 1'b1; a0 = 8'h80; b0 = 8'h01;
        lat = 0;
        do begin @(negedge clk); lat++; end while (!done0 && lat < 40);
        check("hold1_lat", lat, 9);
        check("hold1_diff", {24'd0, diff0}, 32'h7F);
        check("hold1_bout", {31'd0, bout0}, 32'd0);
        a0 = 8'h01; b0 = 8'h02;
        lat = 0;
        do begin @(negedge clk); lat++; end while (!done0 && lat < 40);
        start0 = 1'b0;
        check("hold2_period", lat, 9);
        check("hold2_diff", {24'd0, diff0}, 32'hFF);
        check("hold2_bout", {31'd0, bout0}, 32'd1);
        @(negedge clk);
        check("hold_done_drop", {31'd0, done0}, 32'd0);

        run1(1'b0, 1'b0, 1'b0, 1'b0, "w1_00");
        @(negedge clk);
        run1(1'b0, 1'b1, 1'b1, 1'b1, "w1_01");
        @(negedge clk);
        run1(1'b1, 1'b0, 1'b1, 1'b0, "w1_10");
        @(negedge clk);
        run1(1'b1, 1'b1, 1'b0, 1'b0, "w1_11");
        repeat (3) @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
